// File: rtl/cram_arbiter_if.sv
// Cart RAM arbiter bundle: CPU byte port, savestate byte port, backup word
// port, the single-port byte RAM and the busy flag.
// The arbiter connects through 'slave'; requesters and the RAM model use 'master'.
interface cram_arbiter_if #(
  parameter int AW = 17
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;

  logic          ss_req;
  logic          ss_we;
  logic [AW-1:0] ss_addr;
  logic [7:0]    ss_wdata;
  logic [7:0]    ss_rdata;
  logic          ss_ack;

  logic          bk_req;
  logic          bk_we;
  logic [AW-2:0] bk_addr;
  logic [15:0]   bk_wdata;
  logic [15:0]   bk_rdata;
  logic          bk_ack;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ss_req, ss_we, ss_addr, ss_wdata,
    output ss_rdata, ss_ack,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    output bk_rdata, bk_ack,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ss_req, ss_we, ss_addr, ss_wdata,
    input  ss_rdata, ss_ack,
    output bk_req, bk_we, bk_addr, bk_wdata,
    input  bk_rdata, bk_ack,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/cram_arbiter.sv
// Cart RAM arbiter: shares one single-port byte RAM (1-cycle read latency)
// between the CPU byte port, the savestate byte port and the backup word port.
// Byte access: IDLE -> ACC -> WAIT, ack in the following IDLE cycle.
// Word access: IDLE -> ACC (low byte) -> HI (high byte) -> WAIT.
// Optional feature: define CRAM_ARB_RR_EN for SS/BK round-robin; otherwise
// fixed priority CPU > SS > BK.
module cram_arbiter #(
  parameter int AW = 17
) (
  input  logic            clk_sys,
  input  logic            reset,
  cram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, HI, WAIT} state_t;
  typedef enum logic [1:0] {P_CPU, P_SS, P_BK} port_t;

  state_t        state, state_d;

  logic          cpu_pend, ss_pend, bk_pend;
  logic          cpu_we_q, ss_we_q, bk_we_q;
  logic [AW-1:0] cpu_addr_q, ss_addr_q;
  logic [AW-2:0] bk_addr_q;
  logic [7:0]    cpu_wdata_q, ss_wdata_q;
  logic [15:0]   bk_wdata_q;

  port_t         act_port;
  logic          act_we;
  logic [AW-1:0] act_addr;
  logic [15:0]   act_wdata;
  logic [7:0]    bk_lo;

  logic          eff_cpu, eff_ss, eff_bk, ss_wins;
  logic          gnt_cpu, gnt_ss, gnt_bk, grant_en, lo_cap, done;
  port_t         sel_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;
  logic [AW-1:0] ram_addr_d;
  logic          ram_we_d;
  logic [7:0]    ram_wdata_d;

  assign eff_cpu = cpu_pend | bus.cpu_req;
  assign eff_ss  = ss_pend  | bus.ss_req;
  assign eff_bk  = bk_pend  | bus.bk_req;

`ifdef CRAM_ARB_RR_EN
  // Set when BK was the most recent of SS/BK to be granted; SS then wins ties.
  logic last_bk;

  // Round-robin history between the two lower-priority ports.
  always_ff @(posedge clk_sys) begin
    if (reset)
      last_bk <= 1'b1;
    else if (grant_en && gnt_ss)
      last_bk <= 1'b0;
    else if (grant_en && gnt_bk)
      last_bk <= 1'b1;
  end

  assign ss_wins = last_bk;
`else
  assign ss_wins = 1'b1;
`endif

  assign gnt_cpu = eff_cpu;
  assign gnt_ss  = !eff_cpu && eff_ss && (!eff_bk || ss_wins);
  assign gnt_bk  = !eff_cpu && eff_bk && !gnt_ss;

  // Pick the granted port's fields: captured ones if pending, else the live request.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_port  = P_CPU;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_cpu) begin
      sel_port  = P_CPU;
      sel_we    = cpu_pend ? cpu_we_q    : bus.cpu_we;
      sel_addr  = cpu_pend ? cpu_addr_q  : bus.cpu_addr;
      sel_wdata = {8'h00, cpu_pend ? cpu_wdata_q : bus.cpu_wdata};
    end else if (gnt_ss) begin
      sel_port  = P_SS;
      sel_we    = ss_pend ? ss_we_q    : bus.ss_we;
      sel_addr  = ss_pend ? ss_addr_q  : bus.ss_addr;
      sel_wdata = {8'h00, ss_pend ? ss_wdata_q : bus.ss_wdata};
    end else if (gnt_bk) begin
      sel_port  = P_BK;
      sel_we    = bk_pend ? bk_we_q : bus.bk_we;
      sel_addr  = {(bk_pend ? bk_addr_q : bus.bk_addr), 1'b0};
      sel_wdata = bk_pend ? bk_wdata_q : bus.bk_wdata;
    end
  end

  // Next state and next RAM drive; ram_we defaults low so it is only high for one address cycle.
  always_comb begin
    state_d     = state;
    ram_addr_d  = bus.ram_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = bus.ram_wdata;
    grant_en    = 1'b0;
    lo_cap      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (eff_cpu || eff_ss || eff_bk) begin
          grant_en    = 1'b1;
          state_d     = ACC;
          ram_addr_d  = sel_addr;
          ram_we_d    = sel_we;
          ram_wdata_d = sel_wdata[7:0];
        end
      end
      ACC: begin
        if (act_port == P_BK) begin
          state_d     = HI;
          ram_addr_d  = {act_addr[AW-1:1], 1'b1};
          ram_we_d    = act_we;
          ram_wdata_d = act_wdata[15:8];
        end else begin
          state_d = WAIT;
        end
      end
      HI: begin
        lo_cap  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, pending flags and all outputs; reset aborts any access without an ack.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      cpu_pend      <= 1'b0;
      ss_pend       <= 1'b0;
      bk_pend       <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.ss_ack    <= 1'b0;
      bus.bk_ack    <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ss_rdata  <= '0;
      bus.bk_rdata  <= '0;
    end else begin
      state         <= state_d;
      // A request in its own grant cycle stays pending only if it was not the one granted.
      cpu_pend      <= (grant_en && gnt_cpu) ? (cpu_pend && bus.cpu_req) : (cpu_pend || bus.cpu_req);
      ss_pend       <= (grant_en && gnt_ss)  ? (ss_pend  && bus.ss_req)  : (ss_pend  || bus.ss_req);
      bk_pend       <= (grant_en && gnt_bk)  ? (bk_pend  && bus.bk_req)  : (bk_pend  || bus.bk_req);
      bus.ram_addr  <= ram_addr_d;
      bus.ram_we    <= ram_we_d;
      bus.ram_wdata <= ram_wdata_d;
      bus.cpu_ack   <= done && (act_port == P_CPU);
      bus.ss_ack    <= done && (act_port == P_SS);
      bus.bk_ack    <= done && (act_port == P_BK);
      if (done && !act_we) begin
        case (act_port)
          P_CPU:   bus.cpu_rdata <= bus.ram_rdata;
          P_SS:    bus.ss_rdata  <= bus.ram_rdata;
          default: bus.bk_rdata  <= {bus.ram_rdata, bk_lo};
        endcase
      end
    end
  end

  // Request fields and the active-access snapshot; pure datapath qualified by the flags above.
  // NOTE: these registers are deliberately not reset; the pending flags and state decide when they matter.
  always_ff @(posedge clk_sys) begin
    if (bus.cpu_req) begin
      cpu_we_q    <= bus.cpu_we;
      cpu_addr_q  <= bus.cpu_addr;
      cpu_wdata_q <= bus.cpu_wdata;
    end
    if (bus.ss_req) begin
      ss_we_q    <= bus.ss_we;
      ss_addr_q  <= bus.ss_addr;
      ss_wdata_q <= bus.ss_wdata;
    end
    if (bus.bk_req) begin
      bk_we_q    <= bus.bk_we;
      bk_addr_q  <= bus.bk_addr;
      bk_wdata_q <= bus.bk_wdata;
    end
    if (grant_en) begin
      act_port  <= sel_port;
      act_we    <= sel_we;
      act_addr  <= sel_addr;
      act_wdata <= sel_wdata;
    end
    if (lo_cap)
      bk_lo <= bus.ram_rdata;
  end

  assign bus.busy = (state != IDLE) || cpu_pend || ss_pend || bk_pend;

endmodule

// File: tb/tb_cram_arbiter.sv
// Scoreboard bench for cram_arbiter: each request pushes its expected ack
// cycle and read data; a negedge monitor pops and compares on every ack.
// Define CRAM_ARB_RR_EN here as well when the DUT is built with round-robin.
module tb_cram_arbiter;

  localparam int AW = 17;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cpu_ack_cnt = 0;

  exp_t cpu_q[$];
  exp_t ss_q[$];
  exp_t bk_q[$];

  logic [7:0] mem [0:(1<<AW)-1];

  cram_arbiter_if #(.AW(AW)) bus ();

  cram_arbiter #(.AW(AW)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Ack monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_ack) begin
      cpu_ack_cnt++;
      if (cpu_q.size() == 0) check("cpu_spurious_ack", 32'(bus.cpu_ack), 0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
      end
    end
    if (bus.ss_ack) begin
      if (ss_q.size() == 0) check("ss_spurious_ack", 32'(bus.ss_ack), 0);
      else begin
        e = ss_q.pop_front();
        check("ss_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("ss_rdata", 32'(bus.ss_rdata), 32'(e.data));
      end
    end
    if (bus.bk_ack) begin
      if (bk_q.size() == 0) check("bk_spurious_ack", 32'(bus.bk_ack), 0);
      else begin
        e = bk_q.pop_front();
        check("bk_ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("bk_rdata", 32'(bus.bk_rdata), 32'(e.data));
      end
    end
  end

  // Advance one cycle and drop any request pulses.
  task automatic step();
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.ss_req  = 1'b0;
    bus.bk_req  = 1'b0;
  endtask

  // lat = 0 drives the request without expecting an ack of its own.
  task automatic cpu_set(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                         input int lat, input logic [7:0] exp);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (lat > 0) cpu_q.push_back('{cyc: cyc + lat, rd: !we, data: {8'h00, exp}});
  endtask

  task automatic ss_set(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                        input int lat, input logic [7:0] exp);
    bus.ss_req = 1'b1; bus.ss_we = we; bus.ss_addr = a; bus.ss_wdata = d;
    if (lat > 0) ss_q.push_back('{cyc: cyc + lat, rd: !we, data: {8'h00, exp}});
  endtask

  task automatic bk_set(input bit we, input logic [AW-2:0] a, input logic [15:0] d,
                        input int lat, input logic [15:0] exp);
    bus.bk_req = 1'b1; bus.bk_we = we; bus.bk_addr = a; bus.bk_wdata = d;
    if (lat > 0) bk_q.push_back('{cyc: cyc + lat, rd: !we, data: exp});
  endtask

  // Let the request register, then run until the arbiter is idle (bounded).
  task automatic wait_idle();
    int n = 0;
    step();
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    check("wait_idle_bound", 32'(n >= 60), 0);
    step();
  endtask

  initial begin
    int n0;
    int acks0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ss_req  = 0; bus.ss_we  = 0; bus.ss_addr  = '0; bus.ss_wdata  = '0;
    bus.bk_req  = 0; bus.bk_we  = 0; bus.bk_addr  = '0; bus.bk_wdata  = '0;

    // Reset state: every output low.
    step(); step();
    check("rst_ram", {bus.ram_addr, bus.ram_we, bus.ram_wdata}, 0);
    check("rst_acks", {bus.cpu_ack, bus.ss_ack, bus.bk_ack, bus.busy}, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.ss_rdata, bus.bk_rdata}, 0);
    reset = 1'b0;
    step();

    // CPU write then readback, N+3 each.
    cpu_set(1, 17'h01234, 8'h5A, 3, 8'h00);
    step();
    check("busy_in_acc", 32'(bus.busy), 1);
    wait_idle();
    cpu_set(0, 17'h01234, 8'h00, 3, 8'h5A);
    wait_idle();

    // Three simultaneous writes: CPU N+3, SS N+6, BK N+10.
    cpu_set(1, 17'h01000, 8'h11, 3, 8'h00);
    ss_set(1, 17'h01001, 8'h22, 6, 8'h00);
    bk_set(1, 16'h0900, 16'h3344, 10, 16'h0000);
    wait_idle();
    check("cpu_rdata_hold_after_write", 32'(bus.cpu_rdata), 32'h5A);
    bk_set(0, 16'h0900, 16'h0000, 4, 16'h3344);
    wait_idle();
    ss_set(0, 17'h01000, 8'h00, 3, 8'h11);
    wait_idle();
    cpu_set(0, 17'h01001, 8'h00, 3, 8'h22);
    wait_idle();

    // Top word wraps to the last two bytes of the RAM.
    bk_set(1, 16'hFFFF, 16'h1234, 4, 16'h0000);
    wait_idle();
    cpu_set(0, 17'h1FFFF, 8'h00, 3, 8'h12);
    wait_idle();
    ss_set(0, 17'h1FFFE, 8'h00, 3, 8'h34);
    wait_idle();

    // BK little-endian write, byte readback, word readback.
    bk_set(1, 16'h0100, 16'hBEEF, 4, 16'h0000);
    wait_idle();
    cpu_set(0, 17'h00200, 8'h00, 3, 8'hEF);
    wait_idle();
    cpu_set(0, 17'h00201, 8'h00, 3, 8'hBE);
    wait_idle();
    bk_set(0, 16'h0100, 16'h0000, 4, 16'hBEEF);
    wait_idle();

    // CPU re-request in its own ack cycle: second ack 3 cycles later, 2 acks total.
    acks0 = cpu_ack_cnt;
    cpu_set(0, 17'h00200, 8'h00, 3, 8'hEF);
    step(); step(); step();
    cpu_set(0, 17'h00201, 8'h00, 3, 8'hBE);
    wait_idle();
    repeat (3) step();
    check("cpu_reissue_ack_count", 32'(cpu_ack_cnt - acks0), 2);

    // Reset during the ACC cycle of a CPU write: no ack, ram_we low, idle afterwards.
    cpu_set(1, 17'h00300, 8'h77, 0, 8'h00);
    step();
    reset = 1'b1;
    step();
    check("abort_ram_we", 32'(bus.ram_we), 0);
    check("abort_ack", 32'(bus.cpu_ack), 0);
    step();
    reset = 1'b0;
    step();
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ram_we_after", 32'(bus.ram_we), 0);
    repeat (6) step();

    // SS and BK requested every cycle for 20 cycles.
    n0 = cyc;
`ifdef CRAM_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      ss_q.push_back('{cyc: n0 + 3 + 7 * k, rd: 1'b1, data: 16'h00EF});
      bk_q.push_back('{cyc: n0 + 7 + 7 * k, rd: 1'b1, data: 16'hBEEF});
    end
`else
    for (int k = 0; k < 8; k++)
      ss_q.push_back('{cyc: n0 + 3 + 3 * k, rd: 1'b1, data: 16'h00EF});
    bk_q.push_back('{cyc: n0 + 28, rd: 1'b1, data: 16'hBEEF});
`endif
    for (int i = 0; i < 20; i++) begin
      ss_set(0, 17'h00200, 8'h00, 0, 8'h00);
      bk_set(0, 16'h0100, 16'h0000, 0, 16'h0000);
      step();
    end
    wait_idle();
    repeat (4) step();

    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    check("ss_q_drained", 32'(ss_q.size()), 0);
    check("bk_q_drained", 32'(bk_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cram_arbiter.md
CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 Parameter AW, default 17, is the cart RAM byte-address width (128 KB).
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 cpu_req  in  1  single-cycle request pulse from the mapper/CPU port.
REQ-005 cpu_we / cpu_addr / cpu_wdata  in  1 / AW / 8  write flag, byte address, write data; sampled with cpu_req.
REQ-006 cpu_rdata  out  8  read data; cpu_ack  out  1  one-cycle completion pulse.
REQ-007 ss_req, ss_we, ss_addr[AW-1:0], ss_wdata[7:0] in; ss_rdata[7:0], ss_ack out: savestate byte port, same semantics as the CPU port.
REQ-008 bk_req, bk_we, bk_addr[AW-2:0], bk_wdata[15:0] in; bk_rdata[15:0], bk_ack out: backup word port, little-endian (low byte at even address).
REQ-009 ram_addr[AW-1:0], ram_we, ram_wdata[7:0] out; ram_rdata[7:0] in: single-port byte RAM, synchronous with 1-cycle read latency.
REQ-010 busy  out  1  high whenever the state is not IDLE or any request is pending.

Function
REQ-011 Each port has a pending flag and registered address/we/data; a req pulse sets the flag and captures the fields.
REQ-012 A req arriving while that port is already pending overwrites the captured fields; exactly one ack results.
REQ-013 A req in the same cycle as that port's grant becomes a new pending request; it is never dropped.
REQ-014 States: IDLE, ACC, HI, WAIT; transitions occur only on clk_sys edges.
REQ-015 IDLE: if any (pending | req) exists, grant by priority CPU > SS > BK, drive ram_* for the granted byte, and go to ACC; otherwise stay.
REQ-016 ACC on a byte port: ram_we=0, go to WAIT. ACC on BK: drive the odd address {bk_addr,1} and the high byte, go to HI.
REQ-017 HI: capture ram_rdata into bk_rdata[7:0], set ram_we=0, go to WAIT.
REQ-018 WAIT: capture ram_rdata (the byte port's rdata, or bk_rdata[15:8]), go to IDLE, pulse the granted ack for exactly one cycle.
REQ-019 Latency: request in cycle N gives ack in cycle N+3 for byte ports and N+4 for BK; with continuous demand, byte accesses complete back-to-back every 3 cycles.
REQ-020 ram_we is high only in the cycle a write address is driven; it is never high in WAIT or IDLE.
REQ-021 The rdata outputs hold their value until the next completed read on that port; writes leave rdata unchanged.
REQ-022 A BK transfer is atomic; the worst-case CPU wait is 4 cycles plus its own 3.
REQ-023 Address arithmetic wraps modulo 2^AW; no out-of-range check is performed.

Reset
REQ-024 Reset clears all pending flags, sets the state to IDLE, and drives every output to 0 (ram_*, acks, rdata, busy) on the next edge.
REQ-025 Reset mid-operation aborts the access with no ack and forces ram_we low from that edge on.

Configuration
REQ-026 With CRAM_ARB_RR_EN defined, SS and BK alternate by round-robin (the last-granted of the two loses ties); CPU always keeps top priority.
REQ-027 Without CRAM_ARB_RR_EN, fixed priority CPU > SS > BK applies and no round-robin state exists.

Verification
REQ-028 CPU write 0x5A to 0x01234, then read it back -> cpu_ack at N+3 for each; cpu_rdata=0x5A.
REQ-029 cpu_req, ss_req, and bk_req pulsed in the same cycle -> acks in the order CPU (N+3), SS (N+6), BK (N+10).
REQ-030 BK write 0xBEEF to word 0x0100, then CPU read of 0x00200 and 0x00201 -> 0xEF, 0xBE; BK read returns 0xBEEF.
REQ-031 Reset asserted in the ACC cycle of a CPU write -> no cpu_ack, ram_we=0 afterward, busy=0 after release.
REQ-032 SS and BK requested continuously for 20 cycles -> with CRAM_ARB_RR_EN grants alternate SS, BK, SS…; without it, BK is granted only after SS goes idle.
REQ-033 cpu_req re-pulsed in its own ack cycle -> second ack 3 cycles later; total ack count is 2.
